sub_divider_ctrl: RTL and testbench

- Sequential unsigned restoring divider controller.
- Reuses one DATA_W-bit trial subtracter over DATA_W iterations instead of an array of subtracters.
- Sits in the ALU beside the adder/subtracter blocks; the ALU top issues a start pulse and collects quotient and remainder on done.
- One clock; synchronous, active-high reset.

---
 rtl/alu_pkg.sv | 12 +
 rtl/div_trial_sub.sv | 18 +
 rtl/sub_divider_ctrl.sv | 130 +++++++++++++
 tb/tb_sub_divider_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding and default datapath width.
package alu_pkg;

    localparam int DIV_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (DATA_W+1)-bit trial subtract S - {0,D} with a true borrow-out.
module div_trial_sub #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W:0]   s,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W:0]   diff,
    output logic              borrow
);

    // One extra bit above the operands captures the borrow of an unsigned subtract.
    logic [DATA_W+1:0] wide_diff;

    assign wide_diff = {1'b0, s} - {2'b00, d};
    assign diff      = wide_diff[DATA_W:0];
    assign borrow    = wide_diff[DATA_W+1];

endmodule

// File: rtl/sub_divider_ctrl.sv
// Sequential unsigned restoring divider: one quotient bit per cycle through a shared trial subtracter.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips RUN and raises oDivZero.
module sub_divider_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 5
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iDividend,
    input  logic [DATA_W-1:0] iDivisor,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oQuot,
    output logic [DATA_W-1:0] oRem,
    output logic              oDivZero
);

    div_state_t        state_q, state_d;
    logic [DATA_W:0]   r_q, r_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W:0]   trial_s;
    logic [DATA_W:0]   trial_diff;
    logic              trial_borrow;

`ifdef DIV_ZERO_DETECT_EN
    logic              div_zero_q, div_zero_d;
`endif

    // Next remainder bit comes from the dividend MSB as it shifts out of Q.
    assign trial_s = {r_q[DATA_W-1:0], q_q[DATA_W-1]};

    div_trial_sub #(
        .DATA_W (DATA_W)
    ) u_trial_sub (
        .s      (trial_s),
        .d      (d_q),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d = div_zero_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (iStart) begin
                    r_d     = '0;
                    q_d     = iDividend;
                    d_d     = iDivisor;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_d = 1'b0;
                    if (iDivisor == '0) begin
                        q_d        = '1;
                        r_d        = {1'b0, iDividend};
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // Restoring step: keep the difference only when it did not go negative.
                r_d   = trial_borrow ? trial_s : trial_diff;
                q_d   = {q_q[DATA_W-2:0], ~trial_borrow};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    // The partial remainder never exceeds the divisor, so its top bit stays clear.
    r_msb_zero: assert property (@(posedge iClk) disable iff (iReset) !r_q[DATA_W]);

    assign oBusy = (state_q == RUN);
    assign oDone = (state_q == DONE);
    assign oQuot = q_q;
    assign oRem  = r_q[DATA_W-1:0];

`ifdef DIV_ZERO_DETECT_EN
    assign oDivZero = div_zero_q;
`else
    assign oDivZero = 1'b0;
`endif

endmodule

// File: tb/tb_sub_divider_ctrl.sv
// Self-checking bench for sub_divider_ctrl: directed table, hand-written corner sequences, random vs model.
module tb_sub_divider_ctrl;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;
    localparam int FULL_LAT = DATA_W + 1;
`ifdef DIV_ZERO_DETECT_EN
    localparam int  ZERO_LAT = 1;
    localparam logic ZERO_FLAG = 1'b1;
`else
    localparam int  ZERO_LAT = DATA_W + 1;
    localparam logic ZERO_FLAG = 1'b0;
`endif

    logic              iClk = 1'b0;
    logic              iReset;
    logic              iStart;
    logic [DATA_W-1:0] iDividend;
    logic [DATA_W-1:0] iDivisor;
    logic              oBusy;
    logic              oDone;
    logic [DATA_W-1:0] oQuot;
    logic [DATA_W-1:0] oRem;
    logic              oDivZero;

    int checks = 0;
    int errors = 0;

    sub_divider_ctrl #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iStart    (iStart),
        .iDividend (iDividend),
        .iDivisor  (iDivisor),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oQuot     (oQuot),
        .oRem      (oRem),
        .oDivZero  (oDivZero)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Behavioural reference: plain unsigned division, divide-by-zero by definition.
    task automatic ref_div(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           output logic [DATA_W-1:0] q, output logic [DATA_W-1:0] r,
                           output int lat, output logic dz);
        if (b == 0) begin
            q   = {DATA_W{1'b1}};
            r   = a;
            lat = ZERO_LAT;
            dz  = ZERO_FLAG;
        end else begin
            q   = a / b;
            r   = a % b;
            lat = FULL_LAT;
            dz  = 1'b0;
        end
    endtask

    // Advance one cycle; all sampling and driving happens at the falling edge.
    task automatic tick();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    // Present a start for one cycle; returns at the falling edge of cycle 1.
    task automatic start_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        iStart    = 1'b1;
        iDividend = a;
        iDivisor  = b;
        tick();
        iStart    = 1'b0;
        iDividend = DATA_W'($urandom);
        iDivisor  = DATA_W'($urandom);
    endtask

    // Walk forward from cycle n0 until oDone, counting busy cycles on the way.
    task automatic wait_done(input string name, input int n0, output int n, output int busy_n);
        n      = n0;
        busy_n = 0;
        while (!oDone && n <= 64) begin
            if (oBusy) busy_n++;
            tick();
            n++;
        end
        if (!oDone) check({name, " timeout"}, 32'(oDone), 32'd1);
    endtask

    task automatic run_and_check(input string name, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] eq, er;
        int                elat, n, busy_n;
        logic              edz;
        ref_div(a, b, eq, er, elat, edz);
        start_op(a, b);
        wait_done(name, 1, n, busy_n);
        check({name, " latency"}, 32'(n), 32'(elat));
        check({name, " busy cycles"}, 32'(busy_n), 32'(elat - 1));
        check({name, " quot"}, 32'(oQuot), 32'(eq));
        check({name, " rem"}, 32'(oRem), 32'(er));
        check({name, " divzero"}, 32'(oDivZero), 32'(edz));
        tick();
        check({name, " done pulse"}, 32'(oDone), 32'd0);
        check({name, " quot held"}, 32'(oQuot), 32'(eq));
        check({name, " divzero held"}, 32'(oDivZero), 32'(edz));
    endtask

    initial begin
        vec_t vecs[5];
        int   n, busy_n, done_seen;
        logic [DATA_W-1:0] ra, rb;

        vecs[0] = '{a: 16'd100,    b: 16'd7};
        vecs[1] = '{a: 16'hFFFF,   b: 16'h0001};
        vecs[2] = '{a: 16'd5,      b: 16'd9};
        vecs[3] = '{a: 16'd1234,   b: 16'd0};
        vecs[4] = '{a: 16'hFFFF,   b: 16'hFFFF};

        iReset    = 1'b1;
        iStart    = 1'b0;
        iDividend = '0;
        iDivisor  = '0;
        @(negedge iClk);
        tick();
        iReset = 1'b0;
        check("reset busy", 32'(oBusy), 32'd0);
        check("reset done", 32'(oDone), 32'd0);
        check("reset quot", 32'(oQuot), 32'd0);
        check("reset rem", 32'(oRem), 32'd0);
        check("reset divzero", 32'(oDivZero), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
        end

        // Start during RUN is ignored; a start in the done cycle chains back-to-back.
        start_op(16'd100, 16'd7);
        for (int c = 1; c < 8; c++) tick();
        iStart    = 1'b1;
        iDividend = 16'd50;
        iDivisor  = 16'd5;
        tick();
        iStart = 1'b0;
        wait_done("ignored start", 9, n, busy_n);
        check("ignored start latency", 32'(n), 32'(FULL_LAT));
        check("ignored start quot", 32'(oQuot), 32'd14);
        check("ignored start rem", 32'(oRem), 32'd2);
        start_op(16'd50, 16'd5);
        wait_done("back2back", 1, n, busy_n);
        check("back2back latency", 32'(n), 32'(FULL_LAT));
        check("back2back quot", 32'(oQuot), 32'd10);
        check("back2back rem", 32'(oRem), 32'd0);
        tick();

        // Reset mid-run discards the partial result and suppresses oDone.
        start_op(16'd60000, 16'd3);
        for (int c = 1; c < 9; c++) tick();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        check("midreset busy", 32'(oBusy), 32'd0);
        check("midreset done", 32'(oDone), 32'd0);
        check("midreset quot", 32'(oQuot), 32'd0);
        check("midreset rem", 32'(oRem), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (oDone || oBusy) done_seen++;
            tick();
        end
        check("midreset stays idle", 32'(done_seen), 32'd0);
        run_and_check("after reset", 16'd60000, 16'd3);

        for (int i = 0; i < 40; i++) begin
            ra = DATA_W'($urandom);
            case (i % 4)
                0:       rb = '0;
                1:       rb = DATA_W'($urandom_range(1, 15));
                default: rb = DATA_W'($urandom);
            endcase
            run_and_check($sformatf("rand%0d", i), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
